// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first as a + ~b + 1.
// Result and borrow are held until the next completed operation.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             nb;
    logic             res_bit;
    logic             carry_nx;
    logic [WIDTH-1:0] res_nx;

    assign nb       = ~b_sr[0];
    assign res_bit  = a_sr[0] ^ nb ^ carry;
    assign carry_nx = (a_sr[0] & nb) | (a_sr[0] & carry) | (nb & carry);
    assign res_nx   = {res_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // busy/done are registered views of the state, one cycle behind
            busy <= (state != IDLE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nx;
                    carry  <= carry_nx;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        diff   <= res_nx;
                        borrow <= ~carry_nx;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4.
// Table of operand/result vectors plus hand-written multi-cycle sequences.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One start pulse, then watch 10 edges for latency, busy length, done count
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic eb);
        int first_done;
        int n_done;
        int n_busy;
        logic [W-1:0] d_at;
        logic         b_at;
        first_done = -1;
        n_done = 0;
        n_busy = 0;
        d_at = '0;
        b_at = 1'b0;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    d_at = diff;
                    b_at = borrow;
                end
            end
        end
        chk($sformatf("diff %0d-%0d", va, vb), d_at, ed);
        chk($sformatf("borrow %0d-%0d", va, vb), b_at, eb);
        chk($sformatf("latency %0d-%0d", va, vb), first_done, W + 1);
        chk($sformatf("busy_len %0d-%0d", va, vb), n_busy, W + 1);
        chk($sformatf("done_cnt %0d-%0d", va, vb), n_done, 1);
    endtask

    initial begin
        int n_done;
        int last_k;
        int gap_err;
        int diff_err;

        vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
        vecs[1] = '{4'd3,  4'd9,  4'd10, 1'b1};
        vecs[2] = '{4'd5,  4'd5,  4'd0,  1'b0};
        vecs[3] = '{4'd0,  4'd15, 4'd1,  1'b1};
        vecs[4] = '{4'd15, 4'd0,  4'd15, 1'b0};
        vecs[5] = '{4'd8,  4'd1,  4'd7,  1'b0};
        vecs[6] = '{4'd1,  4'd8,  4'd9,  1'b1};
        vecs[7] = '{4'd12, 4'd12, 4'd0,  1'b0};

        rst = 1'b1;
        start = 1'b1;
        a = 4'd9;
        b = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset diff", diff, 0);
        chk("reset borrow", borrow, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br);

        // start/operand changes during SHIFT are ignored
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
            if (k == 1) begin
                a = 4'd1;
                b = 4'd2;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        chk("ignore_start done_cnt", n_done, 1);
        chk("ignore_start diff", diff, 6);
        chk("ignore_start borrow", borrow, 0);

        // start held: back-to-back operations every W+2 cycles
        @(negedge clk);
        a = 4'd7;
        b = 4'd2;
        start = 1'b1;
        n_done = 0;
        last_k = -1;
        gap_err = 0;
        diff_err = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (diff != 4'd5) diff_err++;
                if (last_k >= 0 && (k - last_k) != W + 2) gap_err++;
                last_k = k;
            end
            if (k == 19) start = 1'b0;
        end
        chk("held done_cnt", n_done, 4);
        chk("held gap_err", gap_err, 0);
        chk("held diff_err", diff_err, 0);

        // reset during SHIFT aborts with no done and clears the result
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort diff", diff, 0);
        chk("abort borrow", borrow, 0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort done_cnt", n_done, 0);
        chk("abort diff_held", diff, 0);

        run_op(4'd4, 4'd1, 4'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
